// File: rtl/inv_transform_decoder_if.sv
// Bus bundle for the inverse transform decoder: coefficient levels and tag in,
// residual block, aligned tag and fill status out.
interface inv_transform_decoder_if #(
  parameter int LEVEL_W = 16
);
  logic                      enable;
  logic [5:0]                QP;
  logic signed [LEVEL_W-1:0] levels [16];
  logic [31:0]               mbnumber;
  logic signed [7:0]         processedres [16];
  logic [31:0]               mbnumber_out;
  logic                      pipeline_full;

  modport master (
    output enable, QP, levels, mbnumber,
    input  processedres, mbnumber_out, pipeline_full
  );

  modport slave (
    input  enable, QP, levels, mbnumber,
    output processedres, mbnumber_out, pipeline_full
  );
endinterface

// File: rtl/inv_transform_decoder.sv
// Four-stage stallable luma 4x4 dequant + H.264 inverse integer transform,
// producing saturated 8-bit residuals with the macroblock tag carried alongside.
module inv_transform_decoder #(
  parameter int LEVEL_W = 16,
  parameter int ACC_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  inv_transform_decoder_if.slave  bus
);

  typedef logic [3:0][ACC_W-1:0] quad_t;

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(32);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-128);

  logic [5:0]               qc;
  logic [5:0]               rem;
  logic [3:0]               qdiv;
  logic [2:0]               qmod;
  logic signed [LEVEL_W-1:0] lev;
  logic signed [ACC_W-1:0]  dq     [16];
  logic signed [ACC_W-1:0]  row_f  [16];
  logic signed [ACC_W-1:0]  col_f  [16];
  quad_t                    row_q;
  quad_t                    col_q;

  logic signed [ACC_W-1:0]  s1_w   [16];
  logic signed [ACC_W-1:0]  s2_f   [16];
  logic signed [ACC_W-1:0]  s3_f   [16];
  logic [31:0]              s1_tag;
  logic [31:0]              s2_tag;
  logic [31:0]              s3_tag;
  logic [2:0]               fill_cnt;

  // Dequant scale: class a on even/even positions, b on odd/odd, c elsewhere.
  function automatic logic [4:0] v_lookup(input logic [2:0] qm, input logic [3:0] idx);
    logic [4:0] va, vb, vc;
    case (qm)
      3'd0:    begin va = 5'd10; vb = 5'd16; vc = 5'd13; end
      3'd1:    begin va = 5'd11; vb = 5'd18; vc = 5'd14; end
      3'd2:    begin va = 5'd13; vb = 5'd20; vc = 5'd16; end
      3'd3:    begin va = 5'd14; vb = 5'd23; vc = 5'd18; end
      3'd4:    begin va = 5'd16; vb = 5'd25; vc = 5'd20; end
      3'd5:    begin va = 5'd18; vb = 5'd29; vc = 5'd23; end
      default: begin va = 5'd10; vb = 5'd16; vc = 5'd13; end
    endcase
    if (!idx[2] && !idx[0])
      return va;
    else if (idx[2] && idx[0])
      return vb;
    else
      return vc;
  endfunction

  function automatic quad_t butterfly(
    input logic signed [ACC_W-1:0] x0,
    input logic signed [ACC_W-1:0] x1,
    input logic signed [ACC_W-1:0] x2,
    input logic signed [ACC_W-1:0] x3
  );
    logic signed [ACC_W-1:0] e0, e1, e2, e3;
    quad_t f;
    e0   = x0 + x2;
    e1   = x0 - x2;
    e2   = (x1 >>> 1) - x3;
    e3   = x1 + (x3 >>> 1);
    f[0] = e0 + e3;
    f[1] = e1 + e2;
    f[2] = e1 - e2;
    f[3] = e0 - e3;
    return f;
  endfunction

  function automatic logic signed [7:0] round_sat(input logic signed [ACC_W-1:0] f);
    logic signed [ACC_W-1:0] t;
    t = (f + RND) >>> 6;
    if (t > MAXV)
      return 8'sd127;
    else if (t < MINV)
      return -8'sd128;
    else
      return t[7:0];
  endfunction

  // QP clamp and divide/modulo by 6 as a restoring compare/subtract chain.
  always_comb begin
    qc   = (bus.QP > 6'd51) ? 6'd51 : bus.QP;
    rem  = qc;
    qdiv = '0;
    if (rem >= 6'd48) begin rem = rem - 6'd48; qdiv[3] = 1'b1; end
    if (rem >= 6'd24) begin rem = rem - 6'd24; qdiv[2] = 1'b1; end
    if (rem >= 6'd12) begin rem = rem - 6'd12; qdiv[1] = 1'b1; end
    if (rem >= 6'd6)  begin rem = rem - 6'd6;  qdiv[0] = 1'b1; end
    qmod = rem[2:0];
  end

  always_comb begin
    lev = '0;
    for (int i = 0; i < 16; i++) begin
      lev   = bus.levels[i];
      dq[i] = (ACC_W'(lev) * $signed(ACC_W'(v_lookup(qmod, 4'(i))))) <<< qdiv;
    end
  end

  always_comb begin
    row_q = '0;
    for (int r = 0; r < 4; r++) begin
      row_q = butterfly(s1_w[4*r], s1_w[4*r+1], s1_w[4*r+2], s1_w[4*r+3]);
      for (int c = 0; c < 4; c++)
        row_f[4*r+c] = $signed(row_q[c]);
    end
  end

  always_comb begin
    col_q = '0;
    for (int c = 0; c < 4; c++) begin
      col_q = butterfly(s2_f[c], s2_f[4+c], s2_f[8+c], s2_f[12+c]);
      for (int r = 0; r < 4; r++)
        col_f[4*r+c] = $signed(col_q[r]);
    end
  end

  // Every stage, tag and the fill counter advance together, so a stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        s1_w[i]             <= '0;
        s2_f[i]             <= '0;
        s3_f[i]             <= '0;
        bus.processedres[i] <= '0;
      end
      s1_tag           <= '0;
      s2_tag           <= '0;
      s3_tag           <= '0;
      bus.mbnumber_out <= '0;
      fill_cnt         <= '0;
    end else if (bus.enable) begin
      for (int i = 0; i < 16; i++) begin
        s1_w[i]             <= dq[i];
        s2_f[i]             <= row_f[i];
        s3_f[i]             <= col_f[i];
        bus.processedres[i] <= round_sat(s3_f[i]);
      end
      s1_tag           <= bus.mbnumber;
      s2_tag           <= s1_tag;
      s3_tag           <= s2_tag;
      bus.mbnumber_out <= s3_tag;
      if (fill_cnt != 3'd4)
        fill_cnt <= fill_cnt + 3'd1;
    end
  end

  assign bus.pipeline_full = (fill_cnt == 3'd4);

endmodule

// File: tb/tb_inv_transform_decoder.sv
// Directed bench for inv_transform_decoder: scoreboard of reference-model blocks
// compared against every output on every cycle.
module tb_inv_transform_decoder;

  typedef struct packed {
    logic [31:0]      tag;
    logic [15:0][7:0] res;
  } exp_t;

  logic clk;
  logic reset;
  inv_transform_decoder_if #(.LEVEL_W(16)) bus ();

  inv_transform_decoder #(.LEVEL_W(16), .ACC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               cur_lv [16];
  exp_t             sb_q [$];
  logic [15:0][7:0] exp_res;
  logic [31:0]      exp_tag;
  logic             exp_full;
  int               fill;
  int               errors;
  int               checks;

  function automatic int vref(input int cls, input int qm);
    int va [6] = '{10, 11, 13, 14, 16, 18};
    int vb [6] = '{16, 18, 20, 23, 25, 29};
    int vc [6] = '{13, 14, 16, 18, 20, 23};
    if (cls == 0) return va[qm];
    if (cls == 1) return vb[qm];
    return vc[qm];
  endfunction

  // Reference: integer division for QP, plain int arithmetic for both transform passes.
  function automatic logic [15:0][7:0] model_block(input int qp);
    int qc, qd, qm, cls, v;
    int e0, e1, e2, e3;
    int w [16];
    int t [16];
    logic [15:0][7:0] res;
    qc = (qp > 51) ? 51 : qp;
    qd = qc / 6;
    qm = qc % 6;
    for (int i = 0; i < 16; i++) begin
      if ((i / 4) % 2 == 0 && (i % 4) % 2 == 0) cls = 0;
      else if ((i / 4) % 2 == 1 && (i % 4) % 2 == 1) cls = 1;
      else cls = 2;
      w[i] = cur_lv[i] * vref(cls, qm) * (1 << qd);
    end
    for (int r = 0; r < 4; r++) begin
      e0 = w[4*r] + w[4*r+2];
      e1 = w[4*r] - w[4*r+2];
      e2 = (w[4*r+1] >>> 1) - w[4*r+3];
      e3 = w[4*r+1] + (w[4*r+3] >>> 1);
      t[4*r]   = e0 + e3;
      t[4*r+1] = e1 + e2;
      t[4*r+2] = e1 - e2;
      t[4*r+3] = e0 - e3;
    end
    for (int c = 0; c < 4; c++) begin
      e0 = t[c] + t[8+c];
      e1 = t[c] - t[8+c];
      e2 = (t[4+c] >>> 1) - t[12+c];
      e3 = t[4+c] + (t[12+c] >>> 1);
      w[c]    = e0 + e3;
      w[4+c]  = e1 + e2;
      w[8+c]  = e1 - e2;
      w[12+c] = e0 - e3;
    end
    for (int i = 0; i < 16; i++) begin
      v = (w[i] + 32) >>> 6;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      res[i] = 8'(v);
    end
    return res;
  endfunction

  task automatic setSingle(input int idx, input int val);
    for (int i = 0; i < 16; i++) cur_lv[i] = 0;
    cur_lv[idx] = val;
  endtask

  task automatic setRandom(input int amp);
    for (int i = 0; i < 16; i++) cur_lv[i] = int'($urandom_range(0, 2 * amp)) - amp;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 16; i++) begin
      checks++;
      assert (bus.processedres[i] === exp_res[i]) else begin
        errors++;
        $error("[TB] FAIL res[%0d] tag=%0h: observed=%0d expected=%0d", i, exp_tag,
               $signed(bus.processedres[i]), $signed(exp_res[i]));
      end
    end
    checks++;
    assert (bus.mbnumber_out === exp_tag) else begin
      errors++;
      $error("[TB] FAIL mbnumber_out: observed=%0h expected=%0h", bus.mbnumber_out, exp_tag);
    end
    checks++;
    assert (bus.pipeline_full === exp_full) else begin
      errors++;
      $error("[TB] FAIL pipeline_full: observed=%0b expected=%0b", bus.pipeline_full, exp_full);
    end
  endtask

  // One clock: drive inputs, queue the model result if sampled, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic en, input int qp, input logic [31:0] tag);
    exp_t item;
    reset        = rst;
    bus.enable   = en;
    bus.QP       = 6'(qp);
    bus.mbnumber = tag;
    for (int i = 0; i < 16; i++) bus.levels[i] = 16'(cur_lv[i]);
    item.res = model_block(qp);
    item.tag = tag;
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      fill    = 0;
      exp_res = '0;
      exp_tag = '0;
    end else if (en) begin
      sb_q.push_back(item);
      if (fill < 4) fill++;
      if (sb_q.size() >= 4) begin
        item    = sb_q.pop_front();
        exp_res = item.res;
        exp_tag = item.tag;
      end
    end
    exp_full = (fill == 4);
    checkOutput();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    fill     = 0;
    exp_res  = '0;
    exp_tag  = '0;
    exp_full = 1'b0;

    $display("[TB] reset with live inputs");
    setRandom(100);
    applyStimulus(1'b1, 1'b1, 20, 32'h1234_5678);
    applyStimulus(1'b1, 1'b1, 20, 32'h1234_5678);

    $display("[TB] DC block, then AC and saturation blocks");
    setSingle(0, 4);
    applyStimulus(1'b0, 1'b1, 12, 32'h0000_00A5);
    setSingle(1, 8);
    applyStimulus(1'b0, 1'b1, 0, 32'h0000_00AC);
    setSingle(0, 2047);
    applyStimulus(1'b0, 1'b1, 51, 32'h0000_0B01);
    setSingle(0, -2047);
    applyStimulus(1'b0, 1'b1, 51, 32'h0000_0B02);
    setSingle(0, 1);
    applyStimulus(1'b0, 1'b1, 51, 32'h0000_0C33);
    applyStimulus(1'b0, 1'b1, 63, 32'h0000_0C3F);
    setSingle(0, 2047);
    applyStimulus(1'b0, 1'b1, 63, 32'h0000_0C40);
    setSingle(5, -3);
    applyStimulus(1'b0, 1'b1, 57, 32'h0000_0C41);

    $display("[TB] random blocks");
    for (int k = 0; k < 6; k++) begin
      setRandom(60);
      applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 63)), 32'h0000_0D00 + 32'(k));
    end

    $display("[TB] streaming with stall");
    for (int k = 1; k <= 3; k++) begin
      setRandom(40);
      applyStimulus(1'b0, 1'b1, 10 + k, 32'(k));
    end
    for (int k = 0; k < 3; k++) begin
      setRandom(500);
      applyStimulus(1'b0, 1'b0, 40, 32'hDEAD_BEEF);
    end
    for (int k = 4; k <= 6; k++) begin
      setRandom(40);
      applyStimulus(1'b0, 1'b1, 10 + k, 32'(k));
    end
    setSingle(0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 0, 32'h0000_0E00 + 32'(k));

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) begin
      setRandom(30);
      applyStimulus(1'b0, 1'b1, 24, 32'h0000_0021 + 32'(k));
    end
    applyStimulus(1'b1, 1'b1, 24, 32'h0000_00FF);
    for (int k = 0; k < 4; k++) begin
      setRandom(30);
      applyStimulus(1'b0, 1'b1, 18, 32'h0000_0031 + 32'(k));
    end

    $display("[TB] enable toggling");
    for (int k = 0; k < 10; k++) begin
      setRandom(50);
      applyStimulus(1'b0, logic'(k % 2 == 0), int'($urandom_range(0, 51)), 32'h0000_0040 + 32'(k));
    end
    setSingle(0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 0, 32'h0000_0F00 + 32'(k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_transform_decoder.md
# inv_transform_decoder

Decoder-side counterpart of the luma 4x4 transform coder. It accepts one 4x4 block of quantized coefficient levels per enabled cycle and rescales (dequantizes) them by QP. It then applies the H.264 4x4 inverse integer transform (rows, then columns), rounds and saturates, and emits an 8-bit signed residual block for the reconstructor. The block is a 4-stage stallable pipeline that carries a 32-bit macroblock tag alongside the data.

## Interface
Parameters:
- LEVEL_W, 16, width of each signed input coefficient level.
- ACC_W, 32, width of internal signed dequant/transform datapath.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; overrides enable.
- enable  input  1  1 = sample inputs and advance the pipeline; 0 = every register holds.
- QP  input  6  quantization parameter; values >51 are treated as 51.
- levels[15:0]  input  LEVEL_W each, signed  coefficient levels; index = 4*row + col.
- mbnumber  input  32  block tag, carried through with the data.
- processedres[15:0]  output  8 each, signed  residual block, same indexing.
- mbnumber_out  output  32  tag aligned with processedres.
- pipeline_full  output  1  1 once processedres holds a valid block.

## Operation
- **S1, capture and dequant:**
  - qc = min(QP, 51); qdiv = qc/6, qmod = qc%6, computed with a compare/subtract chain (no divider).
  - w[i] = levels[i] * V[qmod][class(i)] << qdiv, sign-extended to ACC_W.
  - class a (row and col both even) V = 10,11,13,14,16,18.
  - class b (row and col both odd) V = 16,18,20,23,25,29.
  - class c (otherwise) V = 13,14,16,18,20,23.
  - The tag is registered in parallel.
- **S2, row transform**, per row with inputs x0..x3 indexed by col:
  - e0=x0+x2, e1=x0-x2, e2=(x1>>>1)-x3, e3=x1+(x3>>>1).
  - f0=e0+e3, f1=e1+e2, f2=e1-e2, f3=e0-e3.
- **S3, column transform**: the same butterfly applied per column to the S2 result.
- **S4, output:** r=(f+32)>>>6 (arithmetic), saturated to [-128,127], registered to processedres. The tag is registered to mbnumber_out.
- **Arithmetic:** all intermediate math is signed ACC_W. No overflow occurs for |level| ≤ 2047 at any QP. Larger levels are out of contract.
- **Fill counter:** 3-bit, saturating at 4, increments on each enabled edge while <4. pipeline_full = (count == 4).
- **Stall:** with enable=0, the stage registers, tags, counter and outputs all hold. No block is dropped or duplicated.

## Timing
- **Reset** (synchronous, wins over enable): all stage registers, processedres = 0, mbnumber_out = 0, counter = 0, pipeline_full = 0.
- **Latency:** a block sampled at enabled edge k appears on processedres/mbnumber_out after enabled edge k+3 (4 enabled edges including the sampling edge). Stalled cycles add latency 1:1.
- **pipeline_full** rises in the same cycle the first valid block appears (after the 4th enabled edge since reset). It stays 1 until reset.
- **Throughput:** 1 block per enabled cycle, no bubbles.
- **Reset mid-stream:** all in-flight blocks are discarded. The next valid output requires 4 enabled edges after reset deasserts.
- **Enable toggling every cycle:** output order is preserved and each block is emitted exactly once.

## Test plan
- **Reset:** hold reset 2 cycles with enable=1 and nonzero inputs -> processedres all 0, mbnumber_out=0, pipeline_full=0.
- **DC only:** levels[0]=4, others 0, QP=12, mbnumber=0xA5 -> after 4 enabled edges all 16 processedres = 3, mbnumber_out=0xA5, pipeline_full=1. It is 0 after 3 edges.
- **Saturation:**
  - levels[0]=2047, QP=51 -> all outputs 127.
  - levels[0]=-2047 -> all outputs -128.
  - QP=63 gives results identical to QP=51.
- **Streaming with stall:** tags 1..6 on consecutive cycles, enable low for 3 cycles after tag 3 -> outputs and pipeline_full frozen during the stall. Tags emerge 1..6 in order, once each, with matching data.
- **AC coefficient:** levels[1]=8 (class c), QP=0 -> w=104. Output row values (rows identical) = (104+32)>>6 per column of the f pattern: col0=2, col1=1, col2=-1, col3=-2. Check against a golden model.
- **Reset mid-stream:** assert reset with 3 blocks in flight -> outputs 0, pipeline_full 0. A new block emerges after exactly 4 enabled edges post-reset.
